// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode constants and loader FSM state encoding.
package alu_pkg;
  localparam int DEF_BUS_SIZE = 8;
  localparam int DEF_OPCODE_SIZE = 6;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADD = 6'b100000;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SUB = 6'b100010;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_AND = 6'b100100;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_OR  = 6'b100101;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_XOR = 6'b100110;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_NOR = 6'b100111;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SRL = 6'b000010;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SRA = 6'b000011;
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4
  } loader_state_t;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, debounce when ALU_LOADER_DEBOUNCE_EN is defined, rising-edge press strobe.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic [1:0] sync;
  logic level;
  logic level_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], btn};
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  // level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= sync[1];
    end else begin
      cnt <= cnt + CW'(1);
    end
`else
  assign level = sync[1];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) level_q <= 1'b0;
    else level_q <= level;
  assign press = level & ~level_q;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
endmodule

// File: rtl/alu_input_loader.sv
// alu_input_loader: loads A, B, opcode from switches on button presses and snapshots the ALU result.
// Optional button debounce via ALU_LOADER_DEBOUNCE_EN.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int OPCODE_SIZE     = DEF_OPCODE_SIZE,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUS_SIZE-1:0]    sw,
  input  logic                   btn_a,
  input  logic                   btn_b,
  input  logic                   btn_op,
  input  logic [BUS_SIZE-1:0]    alu_result,
  input  logic                   alu_carry,
  output logic [BUS_SIZE-1:0]    num1,
  output logic [BUS_SIZE-1:0]    num2,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic [BUS_SIZE:0]      led,
  output logic                   result_valid,
  output logic [2:0]             state
);
  loader_state_t cur, nxt;
  logic press_a, press_b, press_op;
  logic ld_a, ld_b, ld_op, cap;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clk(clk), .reset(reset), .btn(btn_a), .press(press_a)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clk(clk), .reset(reset), .btn(btn_b), .press(press_b)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
    .clk(clk), .reset(reset), .btn(btn_op), .press(press_op)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= WAIT_A;
    else cur <= nxt;
  always_comb
    nxt = ld_a ? WAIT_B : ld_b ? WAIT_OP : ld_op ? CAPTURE : (cur == CAPTURE) ? SHOW : cur;
  // a > b > op: a lower-priority strobe in the same cycle is dropped
  always_comb begin
    ld_a  = press_a;
    ld_b  = !press_a && press_b && (cur == WAIT_B);
    ld_op = !press_a && !press_b && press_op && (cur == WAIT_OP || cur == SHOW);
    cap   = (cur == CAPTURE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      num1         <= '0;
      num2         <= '0;
      opcode       <= OPCODE_SIZE'(OP_ADD);
      led          <= '0;
      result_valid <= 1'b0;
    end else begin
      if (ld_a) num1 <= sw;
      if (ld_b) num2 <= sw;
      if (ld_op) opcode <= sw[OPCODE_SIZE-1:0];
      if (cap) led <= {alu_carry, alu_result};
      result_valid <= cap;
    end
  assign state = cur;
endmodule

// File: tb/tb_alu_input_loader.sv
// tb_alu_input_loader: directed self-checking bench with a behavioural ALU on the loader outputs.
module tb_alu_input_loader;
  import alu_pkg::*;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] sw = '0;
  logic btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
  logic [7:0] alu_result;
  logic alu_carry;
  logic [7:0] num1, num2;
  logic [5:0] opcode;
  logic [8:0] led;
  logic result_valid;
  logic [2:0] state;
  logic [8:0] alu_out;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  always #5 clk = ~clk;
  alu_input_loader dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .num1(num1), .num2(num2),
    .opcode(opcode), .led(led), .result_valid(result_valid), .state(state)
  );
  always_comb begin
    alu_out = 9'h0;
    case (opcode)
      OP_ADD: alu_out = {1'b0, num1} + {1'b0, num2};
      OP_SUB: alu_out = {1'b0, num1} - {1'b0, num2};
      OP_AND: alu_out = {1'b0, num1 & num2};
      OP_OR:  alu_out = {1'b0, num1 | num2};
      OP_XOR: alu_out = {1'b0, num1 ^ num2};
      OP_NOR: alu_out = {1'b0, ~(num1 | num2)};
      OP_SRL: alu_out = {1'b0, num1 >> num2};
      OP_SRA: alu_out = {1'b0, $signed(num1) >>> num2};
      default: alu_out = 9'h0;
    endcase
  end
  assign {alu_carry, alu_result} = alu_out;
  always @(negedge clk) if (result_valid) pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [2:0] m, input logic [7:0] v);
    sw = v;
    {btn_op, btn_b, btn_a} = m;
    tick(LAT + 1);
  endtask
  task automatic release_all();
    {btn_op, btn_b, btn_a} = 3'b000;
    tick(LAT + 2);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask
  initial begin
    tick(3);
    check("rst_num1", num1, 0);
    check("rst_num2", num2, 0);
    check("rst_opcode", opcode, 6'b100000);
    check("rst_led", led, 0);
    check("rst_valid", result_valid, 0);
    check("rst_state", state, 0);
    reset = 1'b0;
    tick(1);
`ifdef ALU_LOADER_DEBOUNCE_EN
    sw = 8'h99;
    btn_a = 1'b1;
    tick(10);
    btn_a = 1'b0;
    tick(LAT + 2);
    check("glitch_state", state, 0);
    check("glitch_num1", num1, 0);
`endif
    sw = 8'h05;
    btn_a = 1'b1;
    tick(LAT);
    check("lat_before", state, 0);
    tick(1);
    check("lat_num1", num1, 8'h05);
    check("lat_state", state, 1);
    release_all();
    press(3'b010, 8'h03);
    check("t1_num2", num2, 8'h03);
    check("t1_state_op", state, 2);
    release_all();
    pulses = 0;
    press(3'b100, 8'h20);
    check("t1_opcode", opcode, 6'b100000);
    check("t1_capture", state, 3);
    check("t1_valid_m", result_valid, 0);
    tick(1);
    check("t1_led", led, 9'h008);
    check("t1_valid_m1", result_valid, 1);
    check("t1_show", state, 4);
    tick(1);
    check("t1_valid_m2", result_valid, 0);
    release_all();
    check("t1_pulses", pulses, 1);
    press(3'b001, 8'hFF);
    check("t2_state_a", state, 1);
    release_all();
    press(3'b010, 8'h01);
    release_all();
    press(3'b100, 8'h20);
    tick(1);
    check("t2_led", led, 9'h100);
    release_all();
    do_reset();
    press(3'b010, 8'h77);
    check("t3_b_ign_num2", num2, 0);
    check("t3_b_ign_state", state, 0);
    release_all();
    press(3'b001, 8'h11);
    release_all();
    press(3'b100, 8'hE2);
    check("t3_op_ign_opcode", opcode, 6'b100000);
    check("t3_op_ign_state", state, 1);
    release_all();
    press(3'b011, 8'h22);
    check("t3_ab_num1", num1, 8'h22);
    check("t3_ab_num2", num2, 0);
    check("t3_ab_state", state, 1);
    release_all();
    press(3'b010, 8'h03);
    release_all();
    press(3'b100, 8'h20);
    tick(1);
    check("t4_led_add", led, 9'h025);
    release_all();
    pulses = 0;
    press(3'b100, 8'hE2);
    check("t4_opcode_sub", opcode, 6'b100010);
    check("t4_capture", state, 3);
    tick(1);
    check("t4_led_sub", led, 9'h01F);
    tick(100);
    release_all();
    check("t4_pulses", pulses, 1);
    check("t4_show", state, 4);
    press(3'b001, 8'h44);
    release_all();
    press(3'b010, 8'h55);
    release_all();
    check("t5_wait_op", state, 2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_num1", num1, 0);
    check("t5_num2", num2, 0);
    check("t5_opcode", opcode, 6'b100000);
    check("t5_led", led, 0);
    check("t5_valid", result_valid, 0);
    check("t5_state", state, 0);
    sw = 8'h66;
    btn_a = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(LAT);
    check("t6_held_before", state, 0);
    tick(1);
    check("t6_held_state", state, 1);
    check("t6_held_num1", num1, 8'h66);
    tick(20);
    check("t6_held_once", state, 1);
    release_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
